writeback_stage: RTL and testbench

Final pipeline stage of the RISC-V core, sitting directly upstream of the register file write port. Registers the MEM-stage result, performs sub-word load extraction and sign/zero extension, and drives the register file write-enable, address and data. Also produces EX-stage forwarding selects, a load-use stall request, and decode-stage write-through bypass flags.

---
 rtl/wb_pkg.sv | 23 ++
 rtl/writeback_stage_load_extend.sv | 29 ++
 rtl/writeback_stage.sv | 111 +++++++++++
 tb/tb_writeback_stage.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared writeback-stage types and constants.
// Result source, load funct3 and forwarding select encodings.
package wb_pkg;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10
  } result_src_t;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_MEM  = 2'b01,
    FWD_WB   = 2'b10
  } fwd_sel_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/writeback_stage_load_extend.sv
// Sub-word load extraction with sign/zero extension.
// Undefined funct3 codes return the full word.
module load_extend
  import wb_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[{offset, 3'b000} +: 8];
  assign half_sel = offset[1] ? word[31:16] : word[15:0];

  always_comb begin
    data = word;
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {24'd0, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data = {16'd0, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: WB register, load extension, forwarding,
// load-use detection and decode write-through bypass.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int A_WIDTH = 5,
  parameter int D_WIDTH = 32
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               stall,
  input  logic               flush,
  input  logic               mem_valid,
  input  logic               mem_reg_write,
  input  logic [A_WIDTH-1:0] mem_rd,
  input  logic [1:0]         mem_result_src,
  input  logic [2:0]         mem_funct3,
  input  logic [D_WIDTH-1:0] mem_alu_result,
  input  logic [D_WIDTH-1:0] mem_read_data,
  input  logic [D_WIDTH-1:0] mem_pc_plus4,
  input  logic [A_WIDTH-1:0] ex_rs1,
  input  logic [A_WIDTH-1:0] ex_rs2,
  input  logic               ex_uses_rs1,
  input  logic               ex_uses_rs2,
  input  logic [A_WIDTH-1:0] dec_rs1,
  input  logic [A_WIDTH-1:0] dec_rs2,
  output logic               WE3,
  output logic [A_WIDTH-1:0] A3,
  output logic [D_WIDTH-1:0] WD3,
  output logic [1:0]         fwd_sel1,
  output logic [1:0]         fwd_sel2,
  output logic [D_WIDTH-1:0] mem_fwd_data,
  output logic               load_use_stall,
  output logic               dec_bypass1,
  output logic               dec_bypass2
);

  logic               mem_we;
  logic               mem_load;
  logic [D_WIDTH-1:0] load_data;
  logic [D_WIDTH-1:0] wb_data;
  logic               mem_hit1;
  logic               mem_hit2;
  logic               wb_hit1;
  logic               wb_hit2;

  assign mem_we   = mem_valid & mem_reg_write & (mem_rd != '0);
  assign mem_load = (mem_result_src == RES_LOAD);

  load_extend u_ext (
    .funct3 (mem_funct3),
    .offset (mem_alu_result[1:0]),
    .word   (mem_read_data),
    .data   (load_data)
  );

  assign mem_fwd_data = (mem_result_src == RES_PC4) ?
                        mem_pc_plus4 : mem_alu_result;

  always_comb begin
    case (mem_result_src)
      RES_LOAD: wb_data = load_data;
      RES_PC4:  wb_data = mem_pc_plus4;
      default:  wb_data = mem_alu_result;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      WE3 <= 1'b0;
      A3  <= '0;
      WD3 <= '0;
    end else if (flush) begin
      WE3 <= 1'b0;
    end else if (!stall) begin
      WE3 <= mem_we;
      A3  <= mem_rd;
      WD3 <= wb_data;
    end
  end

  // Loads in MEM cannot forward; they raise load_use_stall instead.
  assign mem_hit1 = mem_we & ~mem_load & (mem_rd == ex_rs1);
  assign mem_hit2 = mem_we & ~mem_load & (mem_rd == ex_rs2);
  assign wb_hit1  = WE3 & (A3 == ex_rs1);
  assign wb_hit2  = WE3 & (A3 == ex_rs2);

  always_comb begin
    fwd_sel1 = FWD_NONE;
    if (ex_uses_rs1) begin
      if (mem_hit1)     fwd_sel1 = FWD_MEM;
      else if (wb_hit1) fwd_sel1 = FWD_WB;
    end
  end

  always_comb begin
    fwd_sel2 = FWD_NONE;
    if (ex_uses_rs2) begin
      if (mem_hit2)     fwd_sel2 = FWD_MEM;
      else if (wb_hit2) fwd_sel2 = FWD_WB;
    end
  end

  assign load_use_stall = mem_we & mem_load &
                          ((ex_uses_rs1 & (mem_rd == ex_rs1)) |
                           (ex_uses_rs2 & (mem_rd == ex_rs2)));

  assign dec_bypass1 = WE3 & (A3 == dec_rs1);
  assign dec_bypass2 = WE3 & (A3 == dec_rs2);

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: vector table, corner sequences,
// and randomized traffic against a behavioural model.
module tb_writeback_stage;
  import wb_pkg::*;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        stall, flush;
  logic        mem_valid, mem_reg_write;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_result_src;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_alu_result, mem_read_data, mem_pc_plus4;
  logic [4:0]  ex_rs1, ex_rs2;
  logic        ex_uses_rs1, ex_uses_rs2;
  logic [4:0]  dec_rs1, dec_rs2;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic [1:0]  fwd_sel1, fwd_sel2;
  logic [31:0] mem_fwd_data;
  logic        load_use_stall, dec_bypass1, dec_bypass2;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 CLK = ~CLK;

  writeback_stage dut (
    .CLK(CLK), .RSTn(RSTn), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
    .mem_rd(mem_rd), .mem_result_src(mem_result_src),
    .mem_funct3(mem_funct3), .mem_alu_result(mem_alu_result),
    .mem_read_data(mem_read_data), .mem_pc_plus4(mem_pc_plus4),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_uses_rs1(ex_uses_rs1), .ex_uses_rs2(ex_uses_rs2),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .WE3(WE3), .A3(A3), .WD3(WD3),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .mem_fwd_data(mem_fwd_data), .load_use_stall(load_use_stall),
    .dec_bypass1(dec_bypass1), .dec_bypass2(dec_bypass2)
  );

  typedef struct {
    logic [1:0]  src;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc4;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] wd;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    mem_valid = 0; mem_reg_write = 0; mem_rd = 0;
    mem_result_src = 2'b00; mem_funct3 = 3'b010;
    mem_alu_result = 0; mem_read_data = 0; mem_pc_plus4 = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_uses_rs1 = 0; ex_uses_rs2 = 0;
    dec_rs1 = 0; dec_rs2 = 0; stall = 0; flush = 0;
  endtask

  task automatic mem_alu(logic [4:0] rd, logic [31:0] v);
    mem_valid = 1; mem_reg_write = 1; mem_rd = rd;
    mem_result_src = 2'b00; mem_alu_result = v;
  endtask

  function automatic logic [31:0] ref_ext(logic [2:0] f3, int off,
                                          logic [31:0] w);
    longint u;
    longint v;
    u = longint'(w);
    case (f3)
      3'b000: begin
        v = (u >> (8 * off)) % 256;
        if (v >= 128) v = v - 256;
      end
      3'b100: v = (u >> (8 * off)) % 256;
      3'b001: begin
        v = (u >> (16 * (off / 2))) % 65536;
        if (v >= 32768) v = v - 65536;
      end
      3'b101: v = (u >> (16 * (off / 2))) % 65536;
      default: v = u;
    endcase
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_data(logic [1:0] src,
      logic [2:0] f3, logic [31:0] alu, logic [31:0] rdata,
      logic [31:0] pc4);
    if (src == 2'd1) return ref_ext(f3, int'(alu % 4), rdata);
    if (src == 2'd2) return pc4;
    return alu;
  endfunction

  // Model of the WB register contents
  logic        m_we;
  logic [4:0]  m_a;
  logic [31:0] m_wd;
  logic        m_known;

  function automatic logic [1:0] ref_fwd(logic [4:0] rs, logic uses);
    if (!uses) return 2'd0;
    if (mem_valid && mem_reg_write && mem_rd != 0 &&
        mem_result_src != 2'd1 && mem_rd == rs) return 2'd1;
    if (m_we && m_a == rs) return 2'd2;
    return 2'd0;
  endfunction

  initial begin
    logic [31:0] w;
    logic [31:0] hw;
    logic [4:0]  ha;
    logic [1:0]  ef;
    w = 32'h80FF7F01;
    vecs[0] = '{2'd1, 3'b000, 32'h1003, w, 0, 5'd1, 1, 32'hFFFFFF80};
    vecs[1] = '{2'd1, 3'b100, 32'h1001, w, 0, 5'd2, 1, 32'h0000007F};
    vecs[2] = '{2'd1, 3'b001, 32'h1002, w, 0, 5'd3, 1, 32'hFFFF80FF};
    vecs[3] = '{2'd1, 3'b101, 32'h1000, w, 0, 5'd4, 1, 32'h00007F01};
    vecs[4] = '{2'd1, 3'b010, 32'h1000, w, 0, 5'd5, 1, 32'h80FF7F01};
    vecs[5] = '{2'd1, 3'b011, 32'h1002, w, 0, 5'd6, 1, 32'h80FF7F01};
    vecs[6] = '{2'd1, 3'b001, 32'h1003, w, 0, 5'd7, 1, 32'hFFFF80FF};
    vecs[7] = '{2'd0, 3'b000, 32'h1234, w, 0, 5'd0, 0, 32'h1234};
    vecs[8] = '{2'd2, 3'b000, 32'h10, w, 32'hDEAD0004, 5'd8, 1,
                32'hDEAD0004};
    vecs[9] = '{2'd3, 3'b000, 32'hCAFEF00D, w, 32'h4, 5'd9, 1,
                32'hCAFEF00D};

    idle();
    RSTn = 0;
    mem_alu(5'd3, 32'h55);
    step();
    step();
    chk("rst_we", 32'(WE3), 0);
    chk("rst_a3", 32'(A3), 0);
    chk("rst_wd", WD3, 0);
    chk("rst_fwd1", 32'(fwd_sel1), 0);
    RSTn = 1;
    step();
    chk("rel_we", 32'(WE3), 1);
    chk("rel_a3", 32'(A3), 3);
    chk("rel_wd", WD3, 32'h55);

    foreach (vecs[i]) begin
      idle();
      mem_valid = 1; mem_reg_write = 1;
      mem_rd = vecs[i].rd; mem_result_src = vecs[i].src;
      mem_funct3 = vecs[i].f3; mem_alu_result = vecs[i].alu;
      mem_read_data = vecs[i].rdata; mem_pc_plus4 = vecs[i].pc4;
      step();
      ex_rs1 = vecs[i].rd; dec_rs1 = vecs[i].rd; ex_uses_rs1 = 1;
      #1;
      ef = (vecs[i].rd == 0) ? 2'd0 : (vecs[i].src == 2'd1 ? 2'd2 : 2'd1);
      chk($sformatf("v%0d_we", i), 32'(WE3), 32'(vecs[i].we));
      if (vecs[i].we) begin
        chk($sformatf("v%0d_a3", i), 32'(A3), 32'(vecs[i].rd));
        chk($sformatf("v%0d_wd", i), WD3, vecs[i].wd);
      end
      chk($sformatf("v%0d_byp", i), 32'(dec_bypass1), 32'(vecs[i].we));
      chk($sformatf("v%0d_fwd", i), 32'(fwd_sel1), 32'(ef));
      chk($sformatf("v%0d_lus", i), 32'(load_use_stall),
          32'(vecs[i].src == 2'd1 && vecs[i].rd != 0));
    end

    idle();
    mem_alu(5'd5, 32'hAAAA);
    step();
    mem_alu(5'd5, 32'hBBBB);
    ex_rs1 = 5; ex_uses_rs1 = 1;
    #1;
    chk("prio_mem", 32'(fwd_sel1), 1);
    chk("prio_data", mem_fwd_data, 32'hBBBB);
    step();
    mem_valid = 0;
    #1;
    chk("prio_wb", 32'(fwd_sel1), 2);
    chk("prio_wd", WD3, 32'hBBBB);
    ex_uses_rs1 = 0;
    #1;
    chk("prio_unused", 32'(fwd_sel1), 0);

    mem_valid = 1; mem_reg_write = 1; mem_rd = 7;
    mem_result_src = 2'd1; mem_funct3 = 3'b010;
    ex_rs2 = 7; ex_uses_rs2 = 1;
    #1;
    chk("lu_stall", 32'(load_use_stall), 1);
    chk("lu_nofwd", 32'(fwd_sel2 == 2'd1), 0);
    ex_uses_rs2 = 0;
    #1;
    chk("lu_unused", 32'(load_use_stall), 0);
    ex_uses_rs2 = 1; mem_rd = 0; ex_rs2 = 0;
    #1;
    chk("lu_x0", 32'(load_use_stall), 0);

    idle();
    mem_alu(5'd9, 32'h99);
    step();
    chk("st_pre", 32'(A3), 9);
    mem_alu(5'd12, 32'h77);
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("st%0d_we", k), 32'(WE3), 1);
      chk($sformatf("st%0d_a3", k), 32'(A3), 9);
      chk($sformatf("st%0d_wd", k), WD3, 32'h99);
    end
    flush = 1;
    step();
    chk("flush_stall_we", 32'(WE3), 0);
    flush = 0; stall = 0;
    mem_alu(5'd10, 32'hA0);
    step();
    dec_rs1 = 10; dec_rs2 = 11;
    #1;
    chk("byp1", 32'(dec_bypass1), 1);
    chk("byp2", 32'(dec_bypass2), 0);
    stall = 1; RSTn = 0;
    step();
    chk("rst_st_we", 32'(WE3), 0);
    chk("rst_st_a3", 32'(A3), 0);
    chk("rst_st_wd", WD3, 0);
    RSTn = 1; stall = 0;

    m_we = 0; m_a = 0; m_wd = 0; m_known = 1;
    for (int i = 0; i < 400; i++) begin
      RSTn = ($urandom_range(39) != 0);
      stall = ($urandom_range(3) == 0);
      flush = ($urandom_range(7) == 0);
      mem_valid = $urandom_range(1);
      mem_reg_write = ($urandom_range(3) != 0);
      mem_rd = 5'($urandom_range(7));
      mem_result_src = 2'($urandom_range(3));
      mem_funct3 = 3'($urandom_range(7));
      mem_alu_result = $urandom;
      mem_read_data = $urandom;
      mem_pc_plus4 = $urandom;
      ex_rs1 = 5'($urandom_range(7));
      ex_rs2 = 5'($urandom_range(7));
      ex_uses_rs1 = $urandom_range(1);
      ex_uses_rs2 = $urandom_range(1);
      dec_rs1 = 5'($urandom_range(7));
      dec_rs2 = 5'($urandom_range(7));
      #1;
      chk("r_fwd1", 32'(fwd_sel1), 32'(ref_fwd(ex_rs1, ex_uses_rs1)));
      chk("r_fwd2", 32'(fwd_sel2), 32'(ref_fwd(ex_rs2, ex_uses_rs2)));
      chk("r_fdata", mem_fwd_data,
          (mem_result_src == 2'd2) ? mem_pc_plus4 : mem_alu_result);
      chk("r_lus", 32'(load_use_stall),
          32'(mem_valid && mem_reg_write && mem_rd != 0 &&
              mem_result_src == 2'd1 &&
              ((ex_uses_rs1 && ex_rs1 == mem_rd) ||
               (ex_uses_rs2 && ex_rs2 == mem_rd))));
      chk("r_byp1", 32'(dec_bypass1), 32'(m_we && m_a == dec_rs1));
      chk("r_byp2", 32'(dec_bypass2), 32'(m_we && m_a == dec_rs2));
      hw = ref_data(mem_result_src, mem_funct3, mem_alu_result,
                    mem_read_data, mem_pc_plus4);
      ha = mem_rd;
      step();
      if (!RSTn) begin
        m_we = 0; m_a = 0; m_wd = 0; m_known = 1;
      end else if (flush) begin
        m_we = 0; m_known = 0;
      end else if (!stall) begin
        m_we = mem_valid && mem_reg_write && ha != 0;
        m_a = ha; m_wd = hw; m_known = 1;
      end
      chk("r_we", 32'(WE3), 32'(m_we));
      if (m_known) begin
        chk("r_a3", 32'(A3), 32'(m_a));
        chk("r_wd", WD3, m_wd);
      end else begin
        m_a = A3; m_wd = WD3;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
